// File: rtl/if_inst_queue.sv
// Fetch instruction queue: credit-based circular FIFO between icache responses and decode.
// Optional same-cycle response bypass when IF_QUEUE_BYPASS_EN is defined.
module if_inst_queue #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   output logic                       req_ready,
   input  logic                       req_fire,
   input  logic                       resp_valid,
   input  logic [31:0]                resp_pc,
   input  logic [31:0]                resp_inst,
   output logic                       out_valid,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_inst,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_q, drop_d;

   logic [31:0] pc_mem   [DEPTH];
   logic [31:0] inst_mem [DEPTH];

   logic [CW:0] occ_sum;
   logic [CW:0] owed_sum;
   logic        fire;
   logic        resp_ok;
   logic        resp_drop;
   logic        resp_keep;
   logic        byp;
   logic        push;
   logic        pop;

   // Credits cover both buffered entries and responses still owed, so a write never finds the queue full.
   assign occ_sum   = {1'b0, count_q} + {1'b0, inflight_q};
   assign owed_sum  = {1'b0, drop_q} + {1'b0, inflight_q};
   assign req_ready = (occ_sum < DEPTH_L) && (owed_sum < DEPTH_L);

   assign fire      = req_fire && req_ready;
   assign resp_ok   = resp_valid && ((inflight_q != '0) || (drop_q != '0));
   assign resp_drop = resp_ok && (drop_q != '0);
   assign resp_keep = resp_ok && (drop_q == '0);

`ifdef IF_QUEUE_BYPASS_EN
   assign byp = resp_keep && (count_q == '0) && !flush;
`else
   assign byp = 1'b0;
`endif

   assign out_valid = (count_q != '0) || byp;
   assign out_pc    = byp ? resp_pc   : pc_mem[rd_ptr_q];
   assign out_inst  = byp ? resp_inst : inst_mem[rd_ptr_q];
   assign count     = count_q;

   // A bypassed response that decode takes immediately never touches storage.
   assign push = resp_keep && !flush && !(byp && out_ready);
   assign pop  = out_ready && (count_q != '0) && !flush;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         inflight_d = '0;
         // Flush-cycle fire belongs to the old stream; a flush-cycle response is thrown away.
         drop_d     = drop_q + inflight_q + CW'(fire) - CW'(resp_ok);
      end else begin
         wr_ptr_d   = wr_ptr_q + PW'(push);
         rd_ptr_d   = rd_ptr_q + PW'(pop);
         count_d    = count_q + CW'(push) - CW'(pop);
         inflight_d = inflight_q + CW'(fire) - CW'(resp_keep);
         drop_d     = drop_q - CW'(resp_drop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= resp_pc;
         inst_mem[wr_ptr_q] <= resp_inst;
      end
   end

endmodule

// File: tb/tb_if_inst_queue.sv
// Bench for if_inst_queue (DEPTH=4): directed scenarios then random traffic against a queue-based model.
module tb_if_inst_queue;
   localparam int D  = 4;
   localparam int CW = $clog2(D) + 1;
`ifdef IF_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, flush, req_fire, resp_valid, out_ready;
   logic [31:0]   resp_pc, resp_inst;
   logic          req_ready, out_valid;
   logic [31:0]   out_pc, out_inst;
   logic [CW-1:0] count;

   if_inst_queue #(.DEPTH(D)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_ready(req_ready), .req_fire(req_fire),
      .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_inst(resp_inst),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
      .out_ready(out_ready), .count(count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: queue contents plus owed-response counters.
   logic [63:0] mq[$];
   int          m_infl = 0;
   int          m_drop = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return ((mq.size() + m_infl) < D) && ((m_drop + m_infl) < D);
   endfunction

   function automatic bit m_byp();
      return BYP && !flush && resp_valid && (m_drop == 0) && (m_infl > 0) && (mq.size() == 0);
   endfunction

   // One clock: compare outputs mid-cycle, then advance the model at the edge.
   task automatic cycle();
      bit          exp_v, fire, ok, consumed;
      logic [63:0] head;
      @(negedge clk);
      chk("req_ready", req_ready, m_ready());
      chk("count", count, mq.size());
      chk("inflight", dut.inflight_q, m_infl);
      chk("drop", dut.drop_q, m_drop);
      exp_v = (mq.size() > 0) || m_byp();
      chk("out_valid", out_valid, exp_v);
      if (exp_v) begin
         head = (mq.size() > 0) ? mq[0] : {resp_pc, resp_inst};
         chk("out_pc", out_pc, head[63:32]);
         chk("out_inst", out_inst, head[31:0]);
      end
      fire     = req_fire && m_ready();
      ok       = resp_valid && (m_infl > 0 || m_drop > 0);
      consumed = m_byp() && out_ready;
      @(posedge clk);
      if (rst) begin
         mq.delete(); m_infl = 0; m_drop = 0;
      end else if (flush) begin
         m_drop = m_drop + m_infl + int'(fire) - int'(ok);
         m_infl = 0;
         mq.delete();
      end else begin
         if (out_ready && mq.size() > 0) void'(mq.pop_front());
         if (ok) begin
            if (m_drop > 0) m_drop--;
            else begin
               m_infl--;
               if (!consumed) mq.push_back({resp_pc, resp_inst});
            end
         end
         m_infl += int'(fire);
      end
      #1;
   endtask

   task automatic idle_in();
      flush = 0; req_fire = 0; resp_valid = 0; out_ready = 0;
      resp_pc = '0; resp_inst = '0;
   endtask

   task automatic do_reset();
      idle_in(); rst = 1; cycle(); rst = 0;
   endtask

   task automatic fire_n(input int n);
      req_fire = 1; repeat (n) cycle(); req_fire = 0;
   endtask

   task automatic resp(input logic [31:0] pc, input logic [31:0] inst);
      resp_valid = 1; resp_pc = pc; resp_inst = inst;
      cycle();
      resp_valid = 0;
   endtask

   initial begin
      idle_in(); rst = 1;
      cycle(); cycle(); rst = 0;
      cycle();

      // Exhaust credit with four requests.
      fire_n(4);
      cycle();
      chk("credit_exhausted", req_ready, 1'b0);

      // Two buffered responses, then drain in order.
      resp(32'hbfc00000, 32'h3c08bfc0);
      resp(32'hbfc00004, 32'h35080000);
      cycle();
      chk("head_pc_buffered", out_pc, 32'hbfc00000);
      out_ready = 1; cycle(); cycle(); out_ready = 0;

      // Build inflight=3, count=1, then flush. With DEPTH=4 the credit is exhausted,
      // so the flush-cycle fire is ignored and three stale responses are owed.
      fire_n(1);
      resp(32'h00001000, 32'h11111111);
      fire_n(1);
      flush = 1; req_fire = 1; cycle(); flush = 0; req_fire = 0;
      chk("drop_after_flush", dut.drop_q, 3);
      fire_n(1);
      for (int i = 0; i < 3; i++) resp(32'h00002000 + 4*i, 32'h22220000 + i);
      out_ready = 1;
      resp(32'h80000180, 32'h00000000);
      cycle(); out_ready = 0;

      // Full-minus-one with push and pop together, pointers wrapping.
      do_reset();
      fire_n(3);
      for (int i = 0; i < 3; i++) resp(32'h00003000 + 4*i, 32'h33330000 + i);
      for (int i = 0; i < 8; i++) begin
         fire_n(1);
         out_ready = 1;
         resp(32'h00004000 + 4*i, 32'h44440000 + i);
         out_ready = 0;
         chk("count_steady", count, 3);
      end
      out_ready = 1; repeat (4) cycle(); out_ready = 0;

      // Empty-queue response with decode ready (bypass vs registered latency).
      do_reset();
      fire_n(1);
      out_ready = 1;
      resp(32'hbfc00008, 32'h24090001);
      cycle(); cycle(); out_ready = 0;

      // Reset wins over flush and traffic.
      do_reset();
      fire_n(4);
      for (int i = 0; i < 3; i++) resp(32'h00005000 + 4*i, 32'h55550000 + i);
      rst = 1; flush = 1; req_fire = 1; resp_valid = 1; resp_pc = 32'h6000; out_ready = 1;
      cycle();
      idle_in(); rst = 0;
      cycle();
      chk("post_reset_ready", req_ready, 1'b1);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst        = ($urandom % 200) == 0;
         flush      = ($urandom % 20) == 0;
         req_fire   = m_ready() && ($urandom % 2);
         resp_valid = ((m_infl + m_drop) > 0) && (($urandom % 3) != 0);
         out_ready  = ($urandom % 4) != 0;
         resp_pc    = $urandom;
         resp_inst  = $urandom;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
